// File: rtl/alu_multicycle_pkg.sv
// Shared opcodes and FSM encoding for the execute-stage ALU.
package alu_multicycle_pkg;

  localparam int unsigned ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'b1101;
  localparam logic [ALU_OP_W-1:0] ALU_MUL = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the ID/EX stage and the ALU.
interface alu_multicycle_if
  import alu_multicycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);

  logic                start_i;
  logic [ALU_OP_W-1:0] aluctr_i;
  logic [WIDTH-1:0]    data1_i;
  logic [WIDTH-1:0]    data2_i;
  logic                flush_i;
  logic                busy_o;
  logic                done_o;
  logic [WIDTH-1:0]    result_o;
  logic                zero_o;

  modport master (
    output start_i, aluctr_i, data1_i, data2_i, flush_i,
    input  busy_o, done_o, result_o, zero_o
  );

  modport slave (
    input  start_i, aluctr_i, data1_i, data2_i, flush_i,
    output busy_o, done_o, result_o, zero_o
  );

endinterface

// File: rtl/alu_multicycle_mul_shift_add.sv
// Iterative radix-2 shift-add multiplier datapath with fixed WIDTH-step latency.
module mul_shift_add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             run_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_c_o,
  output logic [WIDTH-1:0] sum_c_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  // Partial sum including the current multiplier bit; on the last step this is the product.
  assign sum_c_o  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_c_o = run_i && !flush_i && (cnt_q == SHW'(WIDTH - 1));

  // Load on accept, one shift-add step per cycle while running, clear counter on flush.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (run_i) begin
      acc_d    = sum_c_o;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + SHW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle ops plus a fixed-latency iterative multiply.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  alu_multicycle_if.slave  bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             mul_start_c;
  logic             mul_done_c;
  logic [WIDTH-1:0] mul_sum_c;
  logic [WIDTH-1:0] alu_c;
  logic [SHW-1:0]   shamt_c;

  assign shamt_c = bus.data2_i[SHW-1:0];

  // Single-cycle operation results; unknown codes yield zero.
  always_comb begin
    alu_c = '0;
    unique case (bus.aluctr_i)
      ALU_ADD: alu_c = bus.data1_i + bus.data2_i;
      ALU_SUB: alu_c = bus.data1_i - bus.data2_i;
      ALU_AND: alu_c = bus.data1_i & bus.data2_i;
      ALU_XOR: alu_c = bus.data1_i ^ bus.data2_i;
      ALU_SLL: alu_c = bus.data1_i << shamt_c;
      ALU_SRA: alu_c = WIDTH'($signed(bus.data1_i) >>> shamt_c);
      default: alu_c = '0;
    endcase
  end

  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (mul_start_c),
    .run_i    (state_q == ST_MUL),
    .flush_i  (bus.flush_i),
    .a_i      (bus.data1_i),
    .b_i      (bus.data2_i),
    .done_c_o (mul_done_c),
    .sum_c_o  (mul_sum_c)
  );

  // Next-state and result update; flush beats both start and completion.
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    mul_start_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.flush_i && bus.start_i) begin
          if (bus.aluctr_i == ALU_MUL) begin
            mul_start_c = 1'b1;
            state_d     = ST_MUL;
          end else begin
            result_d = alu_c;
            zero_d   = (alu_c == '0);
            done_d   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (bus.flush_i) begin
          state_d = ST_IDLE;
        end else if (mul_done_c) begin
          result_d = mul_sum_c;
          zero_d   = (mul_sum_c == '0);
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy_o   = (state_q == ST_MUL);
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle with hand-computed expectations.
module tb_alu_multicycle;
  import alu_multicycle_pkg::*;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  alu_multicycle_if #(.WIDTH(32)) bus ();

  alu_multicycle #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i  = 1'b1;
    bus.aluctr_i = op;
    bus.data1_i  = a;
    bus.data2_i  = b;
    tick();
    bus.start_i  = 1'b0;
  endtask

  // Accept a mul, then count cycles to done and busy cycles; optionally poke start at cycle 10.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic poke,
                         output int lat, output int busy_cnt);
    issue(ALU_MUL, a, b);
    lat      = 0;
    busy_cnt = (bus.busy_o === 1'b1) ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      if (poke && i == 10) begin
        bus.start_i  = 1'b1;
        bus.aluctr_i = ALU_ADD;
        bus.data1_i  = 32'd1;
        bus.data2_i  = 32'd1;
      end
      tick();
      bus.start_i = 1'b0;
      lat = i;
      if (bus.done_o === 1'b1) break;
      if (bus.busy_o === 1'b1) busy_cnt++;
    end
  endtask

  int lat;
  int bcnt;
  int dcnt;

  initial begin
    nvec         = 0;
    nerr         = 0;
    rst_n        = 1'b0;
    bus.start_i  = 1'b0;
    bus.aluctr_i = 4'b0000;
    bus.data1_i  = '0;
    bus.data2_i  = '0;
    bus.flush_i  = 1'b0;
    tick();
    tick();
    chk("rst_result", bus.result_o, 32'h0);
    chk("rst_zero", 32'(bus.zero_o), 32'h1);
    chk("rst_done", 32'(bus.done_o), 32'h0);
    chk("rst_busy", 32'(bus.busy_o), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single-cycle ops
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'h1);
    chk("add_done", 32'(bus.done_o), 32'h1);
    chk("add_wrap", bus.result_o, 32'h0);
    chk("add_zero", 32'(bus.zero_o), 32'h1);
    tick();
    chk("add_done_pulse", 32'(bus.done_o), 32'h0);

    issue(ALU_SUB, 32'd5, 32'd7);
    chk("sub", bus.result_o, 32'hFFFF_FFFE);
    chk("sub_zero", 32'(bus.zero_o), 32'h0);
    issue(ALU_SLL, 32'h1, 32'h21);
    chk("sll", bus.result_o, 32'h2);
    issue(ALU_SRA, 32'h8000_0000, 32'd4);
    chk("srai", bus.result_o, 32'hF800_0000);
    issue(4'b0010, 32'h1234, 32'h5678);
    chk("badop_done", 32'(bus.done_o), 32'h1);
    chk("badop_result", bus.result_o, 32'h0);
    issue(ALU_SRA, 32'h8000_0000, 32'd4);

    // Back-to-back and / xor
    bus.start_i  = 1'b1;
    bus.aluctr_i = ALU_AND;
    bus.data1_i  = 32'hF0F0;
    bus.data2_i  = 32'h0FF0;
    tick();
    chk("b2b_and_done", 32'(bus.done_o), 32'h1);
    chk("b2b_and", bus.result_o, 32'h00F0);
    bus.aluctr_i = ALU_XOR;
    bus.data1_i  = 32'hFF;
    bus.data2_i  = 32'h0F;
    tick();
    bus.start_i = 1'b0;
    chk("b2b_xor_done", 32'(bus.done_o), 32'h1);
    chk("b2b_xor", bus.result_o, 32'hF0);
    tick();
    chk("b2b_idle_done", 32'(bus.done_o), 32'h0);

    // Reset in the middle of a multiply
    issue(ALU_MUL, 32'd9, 32'd9);
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_busy", 32'(bus.busy_o), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(bus.busy_o), 32'h0);
    chk("mrst_result", bus.result_o, 32'h0);
    chk("mrst_zero", 32'(bus.zero_o), 32'h1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_done", 32'(bus.done_o), 32'h0);
    issue(ALU_ADD, 32'd10, 32'd20);
    chk("post_rst_done", 32'(bus.done_o), 32'h1);
    chk("post_rst_add", bus.result_o, 32'd30);

    // mul 7 x -3 with an ignored start during the multiply
    run_mul(32'd7, 32'hFFFF_FFFD, 1'b1, lat, bcnt);
    chk("mul1_latency", 32'(lat), 32'd32);
    chk("mul1_busy_cycles", 32'(bcnt), 32'd32);
    chk("mul1_done", 32'(bus.done_o), 32'h1);
    chk("mul1_busy_at_done", 32'(bus.busy_o), 32'h0);
    chk("mul1_result", bus.result_o, 32'hFFFF_FFEB);
    tick();
    chk("mul1_no_extra_done", 32'(bus.done_o), 32'h0);

    // mul wrapping to zero, then an add accepted on the done cycle
    run_mul(32'h1_0000, 32'h1_0000, 1'b0, lat, bcnt);
    chk("mul2_latency", 32'(lat), 32'd32);
    chk("mul2_result", bus.result_o, 32'h0);
    chk("mul2_zero", 32'(bus.zero_o), 32'h1);
    issue(ALU_ADD, 32'd2, 32'd3);
    chk("add_on_done_done", 32'(bus.done_o), 32'h1);
    chk("add_on_done", bus.result_o, 32'd5);
    chk("add_on_done_zero", 32'(bus.zero_o), 32'h0);

    // Flush beats start while idle
    bus.flush_i = 1'b1;
    issue(ALU_ADD, 32'd1, 32'd1);
    bus.flush_i = 1'b0;
    chk("idle_flush_done", 32'(bus.done_o), 32'h0);
    chk("idle_flush_result", bus.result_o, 32'd5);
    chk("idle_flush_busy", 32'(bus.busy_o), 32'h0);

    // Flush an in-flight multiply
    issue(ALU_MUL, 32'd3, 32'd4);
    for (int i = 0; i < 14; i++) tick();
    chk("flush_pre_busy", 32'(bus.busy_o), 32'h1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("flush_busy", 32'(bus.busy_o), 32'h0);
    chk("flush_done", 32'(bus.done_o), 32'h0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done_o === 1'b1) dcnt++;
    end
    chk("flush_no_done", 32'(dcnt), 32'd0);
    chk("flush_result_kept", bus.result_o, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
